// File: rtl/frame_scanout.sv
// frame_scanout
//   Scans a double-buffered, upscaled framebuffer out to a video timing stream.
//   The active-area (x, y) coordinate is shifted down by SCALE_SHIFT to a
//   framebuffer pixel. That pixel is read from an external synchronous RAM and
//   re-timed together with hs/vs/de through a two-stage pipeline. Pixels outside
//   the framebuffer are shown as BORDER_COLOR.
//   A small buffer FSM flips the front (scanned) buffer on a frame-boundary swap
//   pulse, but only once the writer has reported the back buffer as complete.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no finished back buffer; a swap re-shows the current frame
//   PENDING | writer finished the back buffer; the next swap flips buffers
//
// Ports
//   clk_rgb       in   pixel clock (only clock)
//   rst_n         in   async active-low reset; release is synchronised
//   ce            in   pixel clock enable
//   x, y          in   active-area column/row from the timing generator
//   hs_in/vs_in/de_in in timing generator sync and data enable
//   swap          in   one-ce-cycle frame-boundary pulse
//   frame_done    in   level: writer finished the back buffer
//   rd_data       in   framebuffer RAM read data
//   rd_en         out  RAM read enable (equals ce)
//   rd_addr       out  RAM read address; MSB selects the buffer
//   frame_ack     out  one-cycle pulse after the flipping ce edge
//   draw_buf      out  buffer the writer draws into (~front)
//   repeat_count  out  frames re-shown without a new frame (saturates at 255)
//   rgb/hs/vs/de  out  pixel colour and re-timed sync/enable
module frame_scanout #(
  parameter int                     X_WIDTH           = 10,
  parameter int                     Y_WIDTH           = 9,
  parameter int                     FB_WIDTH          = 160,
  parameter int                     FB_HEIGHT         = 120,
  parameter int                     SCALE_SHIFT       = 2,
  parameter int                     COLOR_WIDTH       = 12,
  parameter logic [COLOR_WIDTH-1:0] BORDER_COLOR      = '0,
  parameter bit                     HOR_SYNC_POLARITY = 1'b0,
  parameter bit                     VER_SYNC_POLARITY = 1'b0,
  localparam int                    PIX_ADDR_W        = $clog2(FB_WIDTH*FB_HEIGHT),
  localparam int                    ADDR_W            = PIX_ADDR_W + 1
) (
  input  logic                   clk_rgb,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic [X_WIDTH-1:0]     x,
  input  logic [Y_WIDTH-1:0]     y,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   de_in,
  input  logic                   swap,
  input  logic                   frame_done,
  input  logic [COLOR_WIDTH-1:0] rd_data,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   frame_ack,
  output logic                   draw_buf,
  output logic [7:0]             repeat_count,
  output logic [COLOR_WIDTH-1:0] rgb,
  output logic                   hs,
  output logic                   vs,
  output logic                   de
);

  localparam int          FX_W       = X_WIDTH - SCALE_SHIFT;
  localparam int          FY_W       = Y_WIDTH - SCALE_SHIFT;
  localparam logic [31:0] FB_W_U     = FB_WIDTH;
  localparam logic [31:0] FB_H_U     = FB_HEIGHT;
  localparam logic        HS_IDLE    = ~HOR_SYNC_POLARITY;
  localparam logic        VS_IDLE    = ~VER_SYNC_POLARITY;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release waits two clk_rgb edges.
  // ---------------------------------------------------------------------------
  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst_n;

  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // ---------------------------------------------------------------------------
  // Buffer FSM
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_front;
  logic       w_front_nxt;
  logic [7:0] r_repeat;
  logic [7:0] w_repeat_nxt;
  logic       r_frame_ack;
  logic       w_flip;
  logic       w_done;

  // The writer drops frame_done during the ack cycle, so a still-high level
  // there is the old frame and must not re-arm PENDING.
  assign w_done = frame_done & ~r_frame_ack;

  always_ff @(posedge clk_rgb or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_front     <= 1'b0;
      r_repeat    <= 8'd0;
      r_frame_ack <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_front     <= w_front_nxt;
      r_repeat    <= w_repeat_nxt;
      // Not ce-gated: the ack lasts exactly one clk_rgb cycle.
      r_frame_ack <= w_flip;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_front_nxt  = r_front;
    w_repeat_nxt = r_repeat;
    w_flip       = 1'b0;

    if (ce) begin
      case (r_state)
        ST_IDLE: begin
          if (w_done && swap) begin
            w_flip = 1'b1;
          end else if (w_done) begin
            w_state_nxt = ST_PENDING;
          end else if (swap && (r_repeat != 8'hFF)) begin
            w_repeat_nxt = r_repeat + 8'd1;
          end
        end
        ST_PENDING: begin
          if (swap) begin
            w_flip = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase

      if (w_flip) begin
        w_front_nxt  = ~r_front;
        w_repeat_nxt = 8'd0;
        w_state_nxt  = ST_IDLE;
      end
    end
  end

  assign frame_ack    = r_frame_ack;
  assign draw_buf     = ~r_front;
  assign repeat_count = r_repeat;

  // ---------------------------------------------------------------------------
  // Stage 1: coordinate scaling and RAM address
  // ---------------------------------------------------------------------------
  logic [FX_W-1:0]       w_fx;
  logic [FY_W-1:0]       w_fy;
  logic                  w_oob;
  logic [PIX_ADDR_W-1:0] w_lin;
  logic [PIX_ADDR_W-1:0] w_pix_addr;

  assign w_fx  = FX_W'(x >> SCALE_SHIFT);
  assign w_fy  = FY_W'(y >> SCALE_SHIFT);
  assign w_oob = (32'(w_fx) >= FB_W_U) || (32'(w_fy) >= FB_H_U);

  // Any in-range result is below FB_WIDTH*FB_HEIGHT, so PIX_ADDR_W bits hold
  // it exactly; out-of-range results are discarded below.
  assign w_lin      = PIX_ADDR_W'(w_fy) * PIX_ADDR_W'(FB_WIDTH) + PIX_ADDR_W'(w_fx);
  assign w_pix_addr = w_oob ? '0 : w_lin;

  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_hs1;
  logic              r_vs1;
  logic              r_de1;
  logic              r_oob1;

  always_ff @(posedge clk_rgb or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rd_addr <= '0;
      r_hs1     <= HS_IDLE;
      r_vs1     <= VS_IDLE;
      r_de1     <= 1'b0;
      r_oob1    <= 1'b0;
    end else if (ce) begin
      r_rd_addr <= {r_front, w_pix_addr};
      r_hs1     <= hs_in;
      r_vs1     <= vs_in;
      r_de1     <= de_in;
      r_oob1    <= w_oob;
    end
  end

  assign rd_en   = ce;
  assign rd_addr = r_rd_addr;

  // ---------------------------------------------------------------------------
  // Stage 2: colour select and sync re-timing
  // ---------------------------------------------------------------------------
  logic [COLOR_WIDTH-1:0] r_rgb;
  logic                   r_hs;
  logic                   r_vs;
  logic                   r_de;

  always_ff @(posedge clk_rgb or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rgb <= '0;
      r_hs  <= HS_IDLE;
      r_vs  <= VS_IDLE;
      r_de  <= 1'b0;
    end else if (ce) begin
      r_rgb <= r_de1 ? (r_oob1 ? BORDER_COLOR : rd_data) : '0;
      r_hs  <= r_hs1;
      r_vs  <= r_vs1;
      r_de  <= r_de1;
    end
  end

  assign rgb = r_rgb;
  assign hs  = r_hs;
  assign vs  = r_vs;
  assign de  = r_de;

endmodule

// File: tb/tb_frame_scanout.sv
module tb_frame_scanout;

  logic        clk_rgb;
  logic        rst_n;
  logic        ce;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        hs_in;
  logic        vs_in;
  logic        de_in;
  logic        swap;
  logic        frame_done;
  logic [11:0] rd_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        frame_ack;
  logic        draw_buf;
  logic [7:0]  repeat_count;
  logic [11:0] rgb;
  logic        hs;
  logic        vs;
  logic        de;

  int n_checks;
  int n_fail;

  frame_scanout dut (
    .clk_rgb      (clk_rgb),
    .rst_n        (rst_n),
    .ce           (ce),
    .x            (x),
    .y            (y),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .de_in        (de_in),
    .swap         (swap),
    .frame_done   (frame_done),
    .rd_data      (rd_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .frame_ack    (frame_ack),
    .draw_buf     (draw_buf),
    .repeat_count (repeat_count),
    .rgb          (rgb),
    .hs           (hs),
    .vs           (vs),
    .de           (de)
  );

  initial clk_rgb = 1'b0;
  always #5 clk_rgb = ~clk_rgb;

  task automatic tick();
    @(posedge clk_rgb);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    ce         = 1'b1;
    x          = '0;
    y          = '0;
    hs_in      = 1'b1;
    vs_in      = 1'b1;
    de_in      = 1'b0;
    swap       = 1'b0;
    frame_done = 1'b0;
    rd_data    = 12'hABC;

    // reset state
    tick(); tick();
    check("rst_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_de", 32'(de), 32'h0);
    check("rst_hs", 32'(hs), 32'h1);
    check("rst_vs", 32'(vs), 32'h1);
    check("rst_draw_buf", 32'(draw_buf), 32'h1);
    check("rst_frame_ack", 32'(frame_ack), 32'h0);
    check("rst_repeat", 32'(repeat_count), 32'h0);
    rst_n = 1'b1;
    tick(); tick(); tick();

    // basic pixel: x=5,y=9 -> fx=1, fy=2 -> 321
    x = 10'd5; y = 9'd9; de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b1;
    tick();
    check("pix_addr", 32'(rd_addr), 32'd321);
    check("pix_de_lat1", 32'(de), 32'h0);
    check("pix_hs_lat1", 32'(hs), 32'h1);
    tick();
    check("pix_rgb", 32'(rgb), 32'hABC);
    check("pix_de", 32'(de), 32'h1);
    check("pix_hs", 32'(hs), 32'h0);
    check("rd_en_ce1", 32'(rd_en), 32'h1);

    // x boundary: x=640 -> fx=160, out of bounds
    x = 10'd640; y = 9'd0; hs_in = 1'b1; vs_in = 1'b0;
    tick();
    check("oobx_addr", 32'(rd_addr), 32'h0);
    tick();
    check("oobx_rgb", 32'(rgb), 32'h0);
    check("oobx_de", 32'(de), 32'h1);
    check("oobx_vs", 32'(vs), 32'h0);

    // last in-range pixel: fx=159, fy=119 -> 19199
    x = 10'd639; y = 9'd479; vs_in = 1'b1;
    tick();
    check("last_addr", 32'(rd_addr), 32'd19199);
    tick();
    check("last_rgb", 32'(rgb), 32'hABC);

    // y boundary: y=480 -> fy=120
    x = 10'd0; y = 9'd480;
    tick();
    check("ooby_addr", 32'(rd_addr), 32'h0);
    tick();
    check("ooby_rgb", 32'(rgb), 32'h0);

    // blanking: de_in=0 -> rgb=0
    x = 10'd5; y = 9'd9; de_in = 1'b0;
    tick(); tick();
    check("blank_rgb", 32'(rgb), 32'h0);
    check("blank_de", 32'(de), 32'h0);

    // ce toggling
    de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    tick();                      // ce=1 edge: stage1 takes de=1
    ce = 1'b0; de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1; x = 10'd640;
    check("rd_en_ce0", 32'(rd_en), 32'h0);
    tick();                      // ce=0: nothing moves
    check("ce0_de", 32'(de), 32'h0);
    check("ce0_addr", 32'(rd_addr), 32'd321);
    ce = 1'b1;
    tick();                      // second ce edge: outputs appear
    check("ce1_de", 32'(de), 32'h1);
    check("ce1_hs", 32'(hs), 32'h0);
    check("ce1_vs", 32'(vs), 32'h0);
    check("ce1_rgb", 32'(rgb), 32'hABC);
    ce = 1'b0;
    tick();
    check("ce0_hold_de", 32'(de), 32'h1);
    check("ce0_hold_hs", 32'(hs), 32'h0);
    ce = 1'b1;
    tick();
    check("ce1_de_off", 32'(de), 32'h0);
    check("ce1_hs_off", 32'(hs), 32'h1);
    check("ce1_vs_off", 32'(vs), 32'h1);

    // flip via PENDING; swap with ce=0 ignored
    frame_done = 1'b1;
    tick();
    check("pend_draw_buf", 32'(draw_buf), 32'h1);
    check("pend_ack", 32'(frame_ack), 32'h0);
    frame_done = 1'b0; ce = 1'b0; swap = 1'b1;
    tick();
    check("swap_ce0_ack", 32'(frame_ack), 32'h0);
    check("swap_ce0_draw_buf", 32'(draw_buf), 32'h1);
    ce = 1'b1;
    tick();
    check("flip_ack", 32'(frame_ack), 32'h1);
    check("flip_draw_buf", 32'(draw_buf), 32'h0);
    swap = 1'b0; x = 10'd5; y = 9'd9; de_in = 1'b1;
    tick();
    check("flip_ack_gone", 32'(frame_ack), 32'h0);
    check("flip_addr_msb", 32'(rd_addr), 32'h8141);

    // async reset while PENDING mid-frame
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    check("pre_rst_de", 32'(de), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_de", 32'(de), 32'h0);
    check("arst_rgb", 32'(rgb), 32'h0);
    check("arst_addr", 32'(rd_addr), 32'h0);
    check("arst_hs", 32'(hs), 32'h1);
    check("arst_draw_buf", 32'(draw_buf), 32'h1);
    de_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    swap = 1'b1;
    tick();
    check("post_rst_no_flip_ack", 32'(frame_ack), 32'h0);
    check("post_rst_no_flip_buf", 32'(draw_buf), 32'h1);
    check("post_rst_repeat", 32'(repeat_count), 32'h1);
    swap = 1'b0;
    tick();

    // repeat count saturation: 300 more swaps without frame_done
    for (int i = 0; i < 300; i++) begin
      swap = 1'b1;
      tick();
      swap = 1'b0;
      tick();
      if (i == 2) check("repeat_4", 32'(repeat_count), 32'd4);
    end
    check("repeat_sat", 32'(repeat_count), 32'd255);

    // immediate flip from IDLE, frame_done held through the ack cycle
    frame_done = 1'b1; swap = 1'b1;
    tick();
    check("imm_flip_ack", 32'(frame_ack), 32'h1);
    check("imm_flip_buf", 32'(draw_buf), 32'h0);
    check("imm_flip_repeat", 32'(repeat_count), 32'h0);
    swap = 1'b0;
    tick();
    frame_done = 1'b0; swap = 1'b1;
    tick();
    check("ack_cycle_ignored_ack", 32'(frame_ack), 32'h0);
    check("ack_cycle_ignored_buf", 32'(draw_buf), 32'h0);
    check("ack_cycle_ignored_rep", 32'(repeat_count), 32'h1);
    swap = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
